// File: rtl/block_mm_acc.sv
// ============================================================================
// Module      : block_mm_acc
// Description : Sequential TN x TN signed tile multiply-accumulate. The block
//               performs one MAC per cycle and saturates each result on write.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module block_mm_acc #(
  parameter int TN   = 4,
  parameter int DW   = 16,
  parameter int ACCW = 34
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          acc_en,
  input  logic [TN-1:0][TN-1:0][DW-1:0] A,
  input  logic [TN-1:0][TN-1:0][DW-1:0] B,
  output logic [TN-1:0][TN-1:0][DW-1:0] O,
  output logic                          busy,
  output logic                          done
);

  localparam int c_cw = $clog2(TN);
  localparam logic [c_cw-1:0] c_last = c_cw'(TN - 1);
  localparam logic signed [ACCW-1:0] c_max = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] c_min = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  if (TN < 2) begin : g_bad_tn
    $error("block_mm_acc: TN must be at least 2");
  end
  if (ACCW < 2*DW + $clog2(TN)) begin : g_bad_accw
    $error("block_mm_acc: ACCW too narrow for a lossless dot product");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                          r_state;
  state_t                          w_state_next;
  logic [TN-1:0][TN-1:0][DW-1:0]   r_a;
  logic [TN-1:0][TN-1:0][DW-1:0]   r_b;
  logic [TN-1:0][TN-1:0][DW-1:0]   r_o;
  logic                            r_acc_en;
  logic [c_cw-1:0]                 r_row;
  logic [c_cw-1:0]                 r_col;
  logic [c_cw-1:0]                 r_k;
  logic signed [ACCW-1:0]          r_acc;
  logic                            r_done;

  logic                            w_last_k;
  logic                            w_last_col;
  logic                            w_last_row;
  logic                            w_last;
  logic                            w_accept;
  logic [DW-1:0]                   w_o_cur;
  logic signed [2*DW-1:0]          w_prod;
  logic signed [ACCW-1:0]          w_prod_ext;
  logic signed [ACCW-1:0]          w_base;
  logic signed [ACCW-1:0]          w_sum;
  logic [DW-1:0]                   w_sat;

  assign w_last_k   = (r_k   == c_last);
  assign w_last_col = (r_col == c_last);
  assign w_last_row = (r_row == c_last);
  assign w_last     = w_last_k && w_last_col && w_last_row;
  assign w_accept   = (r_state == IDLE) && start;

  // The first MAC of each dot product seeds the accumulator from O (or zero).
  assign w_o_cur    = r_o[r_row][r_col];
  assign w_prod     = $signed(r_a[r_row][r_k]) * $signed(r_b[r_k][r_col]);
  assign w_prod_ext = {{(ACCW-2*DW){w_prod[2*DW-1]}}, w_prod};
  assign w_base     = r_acc_en ? {{(ACCW-DW){w_o_cur[DW-1]}}, w_o_cur} : '0;
  assign w_sum      = ((r_k == '0) ? w_base : r_acc) + w_prod_ext;

  always_comb begin
    w_sat = w_sum[DW-1:0];
    if (w_sum > c_max) begin
      w_sat = c_max[DW-1:0];
    end else if (w_sum < c_min) begin
      w_sat = c_min[DW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_next = RUN;
      RUN:     if (w_last) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_o      <= '0;
      r_acc_en <= 1'b0;
      r_row    <= '0;
      r_col    <= '0;
      r_k      <= '0;
      r_acc    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == RUN) && w_last;
      if (w_accept) begin
        r_a      <= A;
        r_b      <= B;
        r_acc_en <= acc_en;
      end
      if (r_state == RUN) begin
        r_acc <= w_sum;
        if (w_last_k) begin
          r_o[r_row][r_col] <= w_sat;
          r_k               <= '0;
          if (w_last_col) begin
            r_col <= '0;
            r_row <= w_last_row ? '0 : r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end else begin
          r_k <= r_k + 1'b1;
        end
      end
    end
  end

  assign O    = r_o;
  assign busy = (r_state == RUN);
  assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_block_mm_acc.sv
// ============================================================================
// Module      : tb_block_mm_acc
// Description : Scoreboard bench for block_mm_acc using directed tile vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_block_mm_acc;
  localparam int TN   = 4;
  localparam int DW   = 16;
  localparam int ACCW = 34;
  localparam int RUNC = TN * TN * TN;

  typedef logic [TN-1:0][TN-1:0][DW-1:0] tile_t;
  typedef struct {
    int    cyc;
    tile_t o;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  start;
  logic  acc_en;
  tile_t A;
  tile_t B;
  tile_t O;
  logic  busy;
  logic  done;

  exp_t  sb[$];
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;

  block_mm_acc #(.TN(TN), .DW(DW), .ACCW(ACCW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .acc_en (acc_en),
    .A      (A),
    .B      (B),
    .O      (O),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mode 0: s on the diagonal, mode 1: s*(4i+j), mode 2: every element s
  function automatic tile_t fill(input int mode, input int s);
    tile_t t;
    for (int i = 0; i < TN; i++) begin
      for (int j = 0; j < TN; j++) begin
        case (mode)
          0:       t[i][j] = (i == j) ? DW'(s) : '0;
          1:       t[i][j] = DW'(s * (4 * i + j));
          default: t[i][j] = DW'(s);
        endcase
      end
    end
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic go(input tile_t a, input tile_t b, input logic acc, input tile_t expo);
    exp_t e;
    A      = a;
    B      = b;
    acc_en = acc;
    start  = 1'b1;
    e.cyc  = cyc + 1 + RUNC;
    e.o    = expo;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", {31'd0, done}, 32'd1);
  endtask

  // Monitor: pops one expectation per done pulse and checks timing and tile.
  initial begin
    exp_t e;
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (done) begin
          if (prev) chk("done_single_cycle", 32'd1, 32'd0);
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("done_cycle", cyc, e.cyc);
            for (int i = 0; i < TN; i++)
              for (int j = 0; j < TN; j++)
                chk($sformatf("O[%0d][%0d]", i, j), {16'd0, O[i][j]}, {16'd0, e.o[i][j]});
          end
        end
        prev = done;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    rst    = 1'b1;
    start  = 1'b0;
    acc_en = 1'b0;
    A      = '0;
    B      = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < TN; i++)
      for (int j = 0; j < TN; j++)
        chk($sformatf("reset_O[%0d][%0d]", i, j), {16'd0, O[i][j]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // identity times pattern, overwrite; busy must be high for exactly 64 cycles
    go(fill(0, 1), fill(1, 1), 1'b0, fill(1, 1));
    hi = 0;
    for (int n = 0; n < RUNC; n++) begin
      hi += int'(busy);
      @(negedge clk);
    end
    chk("busy_cycles", hi, RUNC);
    chk("busy_fall", {31'd0, busy}, 32'd0);
    @(negedge clk);

    // same product accumulated onto previous result
    go(fill(0, 1), fill(1, 1), 1'b1, fill(1, 2));
    wait_done(RUNC + 10);
    @(negedge clk);

    // positive and negative saturation
    go(fill(2, 32767), fill(2, 32767), 1'b0, fill(2, 32767));
    wait_done(RUNC + 10);
    @(negedge clk);
    go(fill(2, -32768), fill(2, 32767), 1'b0, fill(2, -32768));
    wait_done(RUNC + 10);
    @(negedge clk);

    // start while busy is ignored, operands captured at acceptance
    go(fill(0, 1), fill(1, 1), 1'b0, fill(1, 1));
    repeat (9) @(negedge clk);
    A      = fill(2, 32767);
    B      = fill(2, 32767);
    acc_en = 1'b1;
    start  = 1'b1;
    chk("busy_at_ignored_start", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_done(RUNC + 10);
    @(negedge clk);

    // negative operand with accumulate: pat + (-2I)*pat = -pat
    go(fill(0, -2), fill(1, 1), 1'b1, fill(1, -1));
    wait_done(RUNC + 10);
    @(negedge clk);

    // asynchronous reset mid-run abandons the run
    go(fill(0, 1), fill(1, 1), 1'b0, fill(1, 1));
    repeat (19) @(negedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
    chk("midrun_rst_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < TN; i++)
      for (int j = 0; j < TN; j++)
        chk($sformatf("midrun_rst_O[%0d][%0d]", i, j), {16'd0, O[i][j]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // fresh run after reset, accumulating onto the cleared tile
    go(fill(0, 3), fill(1, 1), 1'b1, fill(1, 3));
    wait_done(RUNC + 10);

    // back-to-back: start during the done cycle, 3pat + pat*2I = 5pat
    go(fill(1, 1), fill(0, 2), 1'b1, fill(1, 5));
    wait_done(RUNC + 10);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/block_mm_acc.md
BLOCK_MM_ACC -- requirements
Module: block_mm_acc

Interface
REQ-001 Parameter TN, default 4, tile dimension (A, B, O are TN x TN); SHALL be >= 2.
REQ-002 Parameter DW, default 16, element width in bits, two's-complement signed.
REQ-003 Parameter ACCW, default 34, accumulator width; SHALL be >= 2*DW + clog2(TN), elaboration error otherwise.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  one-cycle request to begin a tile product.
REQ-007 acc_en  input  1  sampled with start; 1 = add product onto current O, 0 = overwrite O.
REQ-008 A  input  TN x TN x DW  left operand tile, row-major [row][k].
REQ-009 B  input  TN x TN x DW  right operand tile, [k][col].
REQ-010 O  output  TN x TN x DW  result tile, registered.
REQ-011 busy  output  1  high while a product is in progress.
REQ-012 done  output  1  one-cycle pulse marking completion.

Function
REQ-013 start SHALL be accepted only when busy=0; start while busy=1 is ignored with no side effect.
REQ-014 On acceptance, A, B and acc_en SHALL be captured into internal registers; later input changes do not affect the run.
REQ-015 States: IDLE (busy=0) and RUN (busy=1); IDLE->RUN on accepted start; RUN->IDLE on the edge performing the final MAC.
REQ-016 RUN SHALL perform exactly one MAC per cycle, iterating k fastest, then col, then row: TN^3 MAC cycles.
REQ-017 Each MAC SHALL compute the full-precision signed product A[row][k]*B[k][col], sign-extended to ACCW.
REQ-018 At k=0 the accumulator SHALL load base + product, base = sign-extended O[row][col] if captured acc_en=1, else 0; at k>0 accumulator += product.
REQ-019 At k=TN-1 the final sum SHALL be written to O[row][col], saturated to the signed DW range (max 2^(DW-1)-1, min -2^(DW-1)); all other O elements hold.
REQ-020 The accumulator SHALL never overflow given REQ-003; saturation applies only at O write.
REQ-021 Latency: if start is sampled at edge E0, busy=1 after E0, the last O write and busy fall occur at edge E0+TN^3, and done=1 for exactly the cycle following that edge.
REQ-022 done SHALL never be high for more than one consecutive cycle and SHALL be high only after a completed run.
REQ-023 start asserted in the done cycle SHALL be accepted (back-to-back runs, no idle gap required).
REQ-024 Counters row, col, k SHALL be clog2(TN) bits wide and return to 0 at the end of every run.

Reset
REQ-025 rst=1 SHALL immediately force busy=0, done=0, row=col=k=0, accumulator=0, all O elements=0, state IDLE, independent of clk.
REQ-026 rst asserted mid-run SHALL abandon the run; no done pulse is generated for it.
REQ-027 After rst deasserts, the first accepted start SHALL behave as a fresh run per REQ-013 to REQ-021.

Verification (TN=4, DW=16, ACCW=34)
REQ-028 A=identity, B[i][j]=4i+j, acc_en=0, start pulse -> busy high 64 cycles, done pulse exactly 64 cycles after start edge, O=B.
REQ-029 Repeat REQ-028 with acc_en=1 without reset -> O[i][j]=2*(4i+j).
REQ-030 All A=B=0x7FFF, acc_en=0 -> every O=0x7FFF; all A=0x8000, all B=0x7FFF -> every O=0x8000 (saturation both rails).
REQ-031 Start pulse, then start pulse plus changed A/B at cycle 10 -> second start ignored, single done at cycle 64, O equals product of originally captured operands.
REQ-032 rst asserted at cycle 20 of a run -> busy=0, done=0, O all zero immediately; no done pulse; a following start completes normally in 64 cycles.
REQ-033 start asserted during the done cycle with new operands -> second run accepted, second done exactly 64 cycles later, O equals second product.
